// File: rtl/or1200_wb_arb_pkg.sv
// Shared types for the OR1200 two-master Wishbone arbiter: FSM states and
// the bit positions used in the one-hot grant vector.
package or1200_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  localparam int GNT_IDX_I = 0;
  localparam int GNT_IDX_D = 1;

endpackage

// File: rtl/or1200_wb_arb_wdog.sv
// Bounded-wait watchdog: counts unanswered strobe cycles and flags the
// cycle on which the TO_CYCLES-th consecutive one occurs.
module or1200_wb_arb_wdog #(
  parameter int TO_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic inc,
  output logic fire
);

  localparam int CW = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TO_CYCLES - 1);

  logic [CW-1:0] count;

  assign fire = inc && (count == LAST);

  // Clear wins over increment; saturate at the fire point so the count never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      count <= '0;
    end else if (inc && !fire) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/or1200_wb_arb.sv
// Two-master (IWB/DWB) Wishbone arbiter with watchdog abort.
// Define OR1200_WB_ARB_RR_EN for round-robin tie-break; default is fixed D priority.
module or1200_wb_arb
  import or1200_wb_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            iwb_cyc_i,
  input  logic            iwb_stb_i,
  input  logic            iwb_we_i,
  input  logic [AW-1:0]   iwb_adr_i,
  input  logic [DW/8-1:0] iwb_sel_i,
  input  logic [DW-1:0]   iwb_dat_i,
  output logic [DW-1:0]   iwb_dat_o,
  output logic            iwb_ack_o,
  output logic            iwb_err_o,
  output logic            iwb_rty_o,
  input  logic            dwb_cyc_i,
  input  logic            dwb_stb_i,
  input  logic            dwb_we_i,
  input  logic [AW-1:0]   dwb_adr_i,
  input  logic [DW/8-1:0] dwb_sel_i,
  input  logic [DW-1:0]   dwb_dat_i,
  output logic [DW-1:0]   dwb_dat_o,
  output logic            dwb_ack_o,
  output logic            dwb_err_o,
  output logic            dwb_rty_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i,
  output logic [1:0]      gnt_o
);

  arb_state_t state_q, state_d, arb_next;
  logic       tie_pick_d;
  logic       abort_owner_d_q;
  logic [1:0] abort_err_q;
  logic       resp_any;
  logic       owner_i, owner_d;
  logic       wdog_clr, wdog_inc, wdog_fire;

  assign resp_any = wb_ack_i | wb_err_i | wb_rty_i;
  assign owner_i  = (state_q == GNT_I);
  assign owner_d  = (state_q == GNT_D);

`ifdef OR1200_WB_ARB_RR_EN
  logic last_gnt_d_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_gnt_d_q <= 1'b0;
    end else if (state_d == GNT_D) begin
      last_gnt_d_q <= 1'b1;
    end else if (state_d == GNT_I) begin
      last_gnt_d_q <= 1'b0;
    end
  end

  assign tie_pick_d = !last_gnt_d_q;
`else
  assign tie_pick_d = 1'b1;
`endif

  always_comb begin
    arb_next = IDLE;
    if (dwb_cyc_i && (!iwb_cyc_i || tie_pick_d)) begin
      arb_next = GNT_D;
    end else if (iwb_cyc_i) begin
      arb_next = GNT_I;
    end
  end

  // The grant is only released when the owner drops cyc, so bursts and RMW stay atomic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = arb_next;
      GNT_I: if (wdog_fire) state_d = ABORT; else if (!iwb_cyc_i) state_d = arb_next;
      GNT_D: if (wdog_fire) state_d = ABORT; else if (!dwb_cyc_i) state_d = arb_next;
      ABORT: if (!(abort_owner_d_q ? dwb_cyc_i : iwb_cyc_i)) state_d = arb_next;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      abort_err_q     <= '0;
      abort_owner_d_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      abort_err_q <= '0;
      if (wdog_fire) begin
        abort_err_q[GNT_IDX_I] <= owner_i;
        abort_err_q[GNT_IDX_D] <= owner_d;
        abort_owner_d_q        <= owner_d;
      end
    end
  end

  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_sel_o = '0;
    wb_dat_o = '0;
    if (owner_i && iwb_cyc_i) begin
      wb_cyc_o = 1'b1;
      wb_stb_o = iwb_stb_i;
      wb_we_o  = iwb_we_i;
      wb_adr_o = iwb_adr_i;
      wb_sel_o = iwb_sel_i;
      wb_dat_o = iwb_dat_i;
    end else if (owner_d && dwb_cyc_i) begin
      wb_cyc_o = 1'b1;
      wb_stb_o = dwb_stb_i;
      wb_we_o  = dwb_we_i;
      wb_adr_o = dwb_adr_i;
      wb_sel_o = dwb_sel_i;
      wb_dat_o = dwb_dat_i;
    end
  end

  assign iwb_dat_o = wb_dat_i;
  assign dwb_dat_o = wb_dat_i;
  assign iwb_ack_o = owner_i & wb_ack_i;
  assign iwb_rty_o = owner_i & wb_rty_i;
  assign iwb_err_o = (owner_i & wb_err_i) | abort_err_q[GNT_IDX_I];
  assign dwb_ack_o = owner_d & wb_ack_i;
  assign dwb_rty_o = owner_d & wb_rty_i;
  assign dwb_err_o = (owner_d & wb_err_i) | abort_err_q[GNT_IDX_D];

  assign gnt_o[GNT_IDX_I] = owner_i;
  assign gnt_o[GNT_IDX_D] = owner_d;

  // Any state change (a new grant included) restarts the wait budget.
  assign wdog_clr = resp_any || (state_d != state_q) || !(owner_i || owner_d);
  assign wdog_inc = wb_stb_o && !resp_any;

  or1200_wb_arb_wdog #(
    .TO_CYCLES(TO_CYCLES)
  ) u_wdog (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr  (wdog_clr),
    .inc  (wdog_inc),
    .fire (wdog_fire)
  );

endmodule

// File: tb/tb_or1200_wb_arb.sv
// Directed bench for or1200_wb_arb (TO_CYCLES=8); expectations follow
// OR1200_WB_ARB_RR_EN when it is defined for the build.
module tb_or1200_wb_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        iwb_cyc_i, iwb_stb_i, iwb_we_i;
  logic [31:0] iwb_adr_i, iwb_dat_i, iwb_dat_o;
  logic [3:0]  iwb_sel_i;
  logic        iwb_ack_o, iwb_err_o, iwb_rty_o;
  logic        dwb_cyc_i, dwb_stb_i, dwb_we_i;
  logic [31:0] dwb_adr_i, dwb_dat_i, dwb_dat_o;
  logic [3:0]  dwb_sel_i;
  logic        dwb_ack_o, dwb_err_o, dwb_rty_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic [1:0]  gnt_o;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk_i = ~clk_i;

  or1200_wb_arb #(.AW(32), .DW(32), .TO_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i), .iwb_we_i(iwb_we_i),
    .iwb_adr_i(iwb_adr_i), .iwb_sel_i(iwb_sel_i), .iwb_dat_i(iwb_dat_i),
    .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o), .iwb_err_o(iwb_err_o), .iwb_rty_o(iwb_rty_o),
    .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i), .dwb_we_i(dwb_we_i),
    .dwb_adr_i(dwb_adr_i), .dwb_sel_i(dwb_sel_i), .dwb_dat_i(dwb_dat_i),
    .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o), .dwb_rty_o(dwb_rty_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .gnt_o(gnt_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // One call = one clock cycle: drive just after the edge, then settle before checks.
  task automatic applyStimulus(input logic ic, input logic is, input logic [31:0] ia,
                               input logic dc, input logic ds, input logic [31:0] da,
                               input logic ack);
    @(posedge clk_i);
    #1;
    iwb_cyc_i = ic; iwb_stb_i = is; iwb_adr_i = ia;
    dwb_cyc_i = dc; dwb_stb_i = ds; dwb_adr_i = da;
    wb_ack_i  = ack;
    #2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] tieAdr;
    logic [31:0] tieGnt;
    rst_i = 1'b1;
    iwb_cyc_i = 0; iwb_stb_i = 0; iwb_we_i = 0; iwb_adr_i = 0; iwb_sel_i = 4'hF; iwb_dat_i = 32'h1111_1111;
    dwb_cyc_i = 0; dwb_stb_i = 0; dwb_we_i = 0; dwb_adr_i = 0; dwb_sel_i = 4'h3; dwb_dat_i = 32'h2222_2222;
    wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_gnt",   32'(gnt_o), 32'h0);
    checkOutput("rst_wbcyc", 32'(wb_cyc_o), 32'h0);
    checkOutput("rst_err",   32'({iwb_err_o, dwb_err_o}), 32'h0);
    rst_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Single I fetch, slave acks two cycles after the strobe appears
    applyStimulus(1, 1, 32'h100, 0, 0, 0, 0);
    checkOutput("fetch_latency_cyc", 32'(wb_cyc_o), 32'h0);
    applyStimulus(1, 1, 32'h100, 0, 0, 0, 0);
    checkOutput("fetch_cyc", 32'(wb_cyc_o), 32'h1);
    checkOutput("fetch_stb", 32'(wb_stb_o), 32'h1);
    checkOutput("fetch_adr", wb_adr_o, 32'h100);
    checkOutput("fetch_gnt", 32'(gnt_o), 32'h1);
    checkOutput("fetch_sel", 32'(wb_sel_o), 32'hF);
    applyStimulus(1, 1, 32'h100, 0, 0, 0, 0);
    checkOutput("fetch_noack", 32'(iwb_ack_o), 32'h0);
    wb_dat_i = 32'hDEAD_BEEF;
    applyStimulus(1, 1, 32'h100, 0, 0, 0, 1);
    checkOutput("fetch_iack", 32'(iwb_ack_o), 32'h1);
    checkOutput("fetch_dack", 32'(dwb_ack_o), 32'h0);
    checkOutput("fetch_idat", iwb_dat_o, 32'hDEAD_BEEF);
    checkOutput("fetch_ddat", dwb_dat_o, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("fetch_drop_cyc", 32'(wb_cyc_o), 32'h0);
    checkOutput("fetch_drop_ack", 32'(iwb_ack_o), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("fetch_idle_gnt", 32'(gnt_o), 32'h0);

    // First tie: D wins in both builds
    applyStimulus(1, 1, 32'h200, 1, 1, 32'h300, 0);
    applyStimulus(1, 1, 32'h200, 1, 1, 32'h300, 0);
    checkOutput("tie1_gnt", 32'(gnt_o), 32'h2);
    checkOutput("tie1_adr", wb_adr_o, 32'h300);
    applyStimulus(1, 1, 32'h200, 1, 1, 32'h300, 1);
    checkOutput("tie1_dack", 32'(dwb_ack_o), 32'h1);
    checkOutput("tie1_iack", 32'(iwb_ack_o), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("tie1_idle", 32'(gnt_o), 32'h0);

    // Second tie: RR now favours I, fixed priority still favours D
`ifdef OR1200_WB_ARB_RR_EN
    tieGnt = 32'h1; tieAdr = 32'h200;
`else
    tieGnt = 32'h2; tieAdr = 32'h300;
`endif
    applyStimulus(1, 1, 32'h200, 1, 1, 32'h300, 0);
    applyStimulus(1, 1, 32'h200, 1, 1, 32'h300, 0);
    checkOutput("tie2_gnt", 32'(gnt_o), tieGnt);
    checkOutput("tie2_adr", wb_adr_o, tieAdr);
    if (tieGnt == 32'h1) applyStimulus(0, 0, 0, 1, 1, 32'h300, 0);
    else                 applyStimulus(1, 1, 32'h200, 0, 0, 0, 0);
    checkOutput("tie2_drop_gnt", 32'(gnt_o), tieGnt);
    checkOutput("tie2_drop_cyc", 32'(wb_cyc_o), 32'h0);
    if (tieGnt == 32'h1) applyStimulus(0, 0, 0, 1, 1, 32'h300, 0);
    else                 applyStimulus(1, 1, 32'h200, 0, 0, 0, 0);
    checkOutput("tie2_handoff_gnt", 32'(gnt_o), 32'h3 ^ tieGnt);
    checkOutput("tie2_handoff_adr", wb_adr_o, 32'h500 - tieAdr);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // D 4-beat burst with I waiting: no interleave, direct 10 -> 01 handoff
    applyStimulus(0, 0, 0, 1, 1, 32'h400, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 32'h600, 1, 1, 32'h400 + 32'(4 * k), 1);
      checkOutput($sformatf("burst%0d_gnt", k), 32'(gnt_o), 32'h2);
      checkOutput($sformatf("burst%0d_adr", k), wb_adr_o, 32'h400 + 32'(4 * k));
      checkOutput($sformatf("burst%0d_acks", k), 32'({iwb_ack_o, dwb_ack_o}), 32'h1);
    end
    applyStimulus(1, 1, 32'h600, 0, 0, 0, 0);
    checkOutput("burst_release_gnt", 32'(gnt_o), 32'h2);
    applyStimulus(1, 1, 32'h600, 0, 0, 0, 0);
    checkOutput("burst_handoff_gnt", 32'(gnt_o), 32'h1);
    checkOutput("burst_handoff_adr", wb_adr_o, 32'h600);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Watchdog: unanswered D write aborts with a one-cycle err in cycle 9
    dwb_we_i = 1'b1;
    applyStimulus(0, 0, 0, 1, 1, 32'h500, 0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0, 0, 1, 1, 32'h500, 0);
      checkOutput($sformatf("wdog_c%0d_cyc", k), 32'(wb_cyc_o), 32'h1);
      checkOutput($sformatf("wdog_c%0d_err", k), 32'(dwb_err_o), 32'h0);
    end
    applyStimulus(0, 0, 0, 1, 1, 32'h500, 0);
    checkOutput("wdog_fire_derr", 32'(dwb_err_o), 32'h1);
    checkOutput("wdog_fire_ierr", 32'(iwb_err_o), 32'h0);
    checkOutput("wdog_fire_cyc",  32'(wb_cyc_o), 32'h0);
    checkOutput("wdog_fire_stb",  32'(wb_stb_o), 32'h0);
    applyStimulus(1, 1, 32'h700, 1, 1, 32'h500, 1);
    checkOutput("wdog_late_ack", 32'(dwb_ack_o), 32'h0);
    checkOutput("wdog_err_pulse", 32'(dwb_err_o), 32'h0);
    dwb_we_i = 1'b0;
    applyStimulus(1, 1, 32'h700, 0, 0, 0, 0);
    checkOutput("wdog_abort_gnt", 32'(gnt_o), 32'h0);
    applyStimulus(1, 1, 32'h700, 0, 0, 0, 0);
    checkOutput("wdog_regrant_gnt", 32'(gnt_o), 32'h1);
    checkOutput("wdog_regrant_cyc", 32'(wb_cyc_o), 32'h1);
    checkOutput("wdog_regrant_adr", wb_adr_o, 32'h700);

    // Reset in the middle of an I transfer
    rst_i = 1'b1;
    applyStimulus(1, 1, 32'h700, 0, 0, 0, 1);
    checkOutput("rstmid_gnt", 32'(gnt_o), 32'h0);
    checkOutput("rstmid_bus", 32'({wb_cyc_o, wb_stb_o}), 32'h0);
    checkOutput("rstmid_adr", wb_adr_o, 32'h0);
    checkOutput("rstmid_ack", 32'(iwb_ack_o), 32'h0);
    rst_i = 1'b0;
    applyStimulus(1, 1, 32'h700, 0, 0, 0, 0);
    checkOutput("rstmid_regrant_gnt", 32'(gnt_o), 32'h1);
    checkOutput("rstmid_regrant_cyc", 32'(wb_cyc_o), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
